// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared instruction/data memory. Port 0 is the core controller
// and port 1 is the loader/debug DMA. It grants at most one access per cycle, supports
// locked bursts capped at MAX_BURST grants, and steers read data back to the requester
// that issued the read.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MAX_BURST = 8,
    localparam int unsigned BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [BE_W-1:0]   be0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [BE_W-1:0]   be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StArb, StHold0, StHold1} state_t;

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic [7:0]          burst_q, burst_d;
    logic                g0, g1;
    logic                own1, own_req, own_lock;
    logic [READ_LAT-1:0] tag_vld_q, tag_port_q;

    // Arbitration decision and next state for the ownership FSM
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        burst_d  = burst_q;
        g0       = 1'b0;
        g1       = 1'b0;
        own1     = (state_q == StHold1);
        own_req  = own1 ? req1 : req0;
        own_lock = own1 ? lock1 : lock0;
        unique case (state_q)
            StArb: begin
                if (req0 && (!req1 || !rr_q)) begin
                    g0 = 1'b1;
                end else if (req1) begin
                    g1 = 1'b1;
                end
                if (g0 || g1) begin
                    // Favour the port that just lost out
                    rr_d = g0;
                    // A one-grant cap means a lock can never extend past its first access
                    if (((g0 && lock0) || (g1 && lock1)) && (MAX_BURST > 1)) begin
                        state_d = g0 ? StHold0 : StHold1;
                        burst_d = 8'd1;
                    end
                end
            end
            StHold0, StHold1: begin
                g0 = !own1 && req0;
                g1 = own1 && req1;
                if (own_req) begin
                    burst_d = burst_q + 8'd1;
                    if (!own_lock) begin
                        state_d = StArb;
                        burst_d = 8'd0;
                    end else if (burst_q + 8'd1 == MaxBurst) begin
                        // Burst cap reached: hand priority to the starved port
                        state_d = StArb;
                        burst_d = 8'd0;
                        rr_d    = !own1;
                    end
                end else if (!own_lock) begin
                    state_d = StArb;
                    burst_d = 8'd0;
                end
            end
            default: state_d = StArb;
        endcase
    end

    // FSM, round-robin pointer and burst counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StArb;
            rr_q    <= 1'b0;
            burst_q <= 8'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    // Grants and memory-side mux; everything is forced low while reset is held
    always_comb begin
        gnt0      = g0 && !rst;
        gnt1      = g1 && !rst;
        mem_en    = gnt0 || gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_be    = be0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_be    = be1;
        end
    end

    // Read tag pipeline tracks which port each in-flight read belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            tag_vld_q[0]  <= mem_en && !mem_we;
            tag_port_q[0] <= gnt1;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_port_q[i] <= tag_port_q[i-1];
            end
        end
    end

    // Return path: steer memory data to the owning port, zero otherwise
    always_comb begin
        rvalid0 = tag_vld_q[READ_LAT-1] && !tag_port_q[READ_LAT-1] && !rst;
        rvalid1 = tag_vld_q[READ_LAT-1] && tag_port_q[READ_LAT-1] && !rst;
        rdata0  = rvalid0 ? mem_rdata : '0;
        rdata1  = rvalid1 ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 2) share the same request
// stimulus, each with its own memory model, and are compared every cycle against a
// transaction-level reference of the arbitration and read-return rules.
module tb_mem_port_arbiter;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_mem;
    logic        req[2], lock[2], we[2];
    logic [31:0] addr[2], wdata[2];
    logic [3:0]  be[2];

    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_en_a, mem_we_a;
    logic [31:0] rdata0_a, rdata1_a, mem_addr_a, mem_wdata_a, rd_a;
    logic [3:0]  mem_be_a;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_en_b, mem_we_b;
    logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, rd_b1, rd_b2;
    logic [3:0]  mem_be_b;

    logic [31:0] mem_a[16], mem_b[16], mmem[16];

    // Reference model state
    int          owner, favour, run, cyc, last_g;
    int          due1_port[int], due2_port[int];
    logic [31:0] due1_data[int], due2_data[int];
    int          checks, errors;
    bit          pend[2];
    logic        s_gnt0_a, s_gnt1_a, s_rvalid0_a, s_rvalid1_a, s_rvalid0_b;
    logic [31:0] s_rdata0_a, s_rdata0_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .MAX_BURST(MAXB)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req[0]), .lock0(lock[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .be0(be[0]),
        .req1(req[1]), .lock1(lock[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .be1(be[1]),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_be(mem_be_a), .mem_rdata(rd_a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2), .MAX_BURST(MAXB)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req[0]), .lock0(lock[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .be0(be[0]),
        .req1(req[1]), .lock1(lock[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .be1(be[1]),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b), .mem_rdata(rd_b2)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : 32'hA5000000 + 32'(i) * 32'h01010101;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        for (int k = 0; k < 4; k++) if (b[k]) o[8*k +: 8] = n[8*k +: 8];
        return o;
    endfunction

    // Memory macro models; idle cycles return junk so the rdata gating is exercised
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (mem_en_a && mem_we_a)
                mem_a[mem_addr_a[5:2]] <= merge(mem_a[mem_addr_a[5:2]], mem_wdata_a, mem_be_a);
            if (mem_en_b && mem_we_b)
                mem_b[mem_addr_b[5:2]] <= merge(mem_b[mem_addr_b[5:2]], mem_wdata_b, mem_be_b);
        end
        rd_a  <= (mem_en_a && !mem_we_a) ? mem_a[mem_addr_a[5:2]] : $urandom;
        rd_b1 <= (mem_en_b && !mem_we_b) ? mem_b[mem_addr_b[5:2]] : $urandom;
        rd_b2 <= rd_b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; favour = 0; run = 0;
        due1_port.delete(); due1_data.delete(); due2_port.delete(); due2_data.delete();
    endtask

    task automatic set_port(input int p, input logic r, input logic l, input logic w,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req[p] = r; lock[p] = l; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    endtask

    task automatic check_reset();
        check("rst_gnt0_a", gnt0_a, 0);     check("rst_gnt1_a", gnt1_a, 0);
        check("rst_en_a", mem_en_a, 0);     check("rst_we_a", mem_we_a, 0);
        check("rst_addr_a", mem_addr_a, 0); check("rst_wdata_a", mem_wdata_a, 0);
        check("rst_be_a", mem_be_a, 0);     check("rst_rv0_a", rvalid0_a, 0);
        check("rst_rv1_a", rvalid1_a, 0);   check("rst_rd0_a", rdata0_a, 0);
        check("rst_rd1_a", rdata1_a, 0);
        check("rst_gnt0_b", gnt0_b, 0);     check("rst_gnt1_b", gnt1_b, 0);
        check("rst_en_b", mem_en_b, 0);     check("rst_we_b", mem_we_b, 0);
        check("rst_addr_b", mem_addr_b, 0); check("rst_wdata_b", mem_wdata_b, 0);
        check("rst_be_b", mem_be_b, 0);     check("rst_rv0_b", rvalid0_b, 0);
        check("rst_rv1_b", rvalid1_b, 0);   check("rst_rd0_b", rdata0_b, 0);
        check("rst_rd1_b", rdata1_b, 0);
    endtask

    // One clock cycle: predict, compare, then advance the model at the clock edge
    task automatic step(input bit rst_after);
        int          g, pa, pb;
        logic [31:0] ea, ed, da, db;
        logic [3:0]  eb;
        logic        ewe;
        #1;
        g = -1;
        if (owner < 0) begin
            if (req[0] && req[1]) g = favour;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end else if (req[owner]) begin
            g = owner;
        end
        ewe = 0; ea = 0; ed = 0; eb = 0;
        if (g >= 0) begin
            ewe = we[g]; ea = addr[g]; ed = wdata[g]; eb = be[g];
        end
        pa = -1; da = 0;
        if (due1_port.exists(cyc)) begin
            pa = due1_port[cyc]; da = due1_data[cyc];
            due1_port.delete(cyc); due1_data.delete(cyc);
        end
        pb = -1; db = 0;
        if (due2_port.exists(cyc)) begin
            pb = due2_port[cyc]; db = due2_data[cyc];
            due2_port.delete(cyc); due2_data.delete(cyc);
        end
        check("gnt0_a", gnt0_a, g == 0);    check("gnt1_a", gnt1_a, g == 1);
        check("en_a", mem_en_a, g >= 0);    check("we_a", mem_we_a, ewe);
        check("addr_a", mem_addr_a, ea);    check("wdata_a", mem_wdata_a, ed);
        check("be_a", mem_be_a, eb);
        check("gnt0_b", gnt0_b, g == 0);    check("gnt1_b", gnt1_b, g == 1);
        check("en_b", mem_en_b, g >= 0);    check("we_b", mem_we_b, ewe);
        check("addr_b", mem_addr_b, ea);    check("wdata_b", mem_wdata_b, ed);
        check("be_b", mem_be_b, eb);
        check("rvalid0_a", rvalid0_a, pa == 0);
        check("rvalid1_a", rvalid1_a, pa == 1);
        check("rdata0_a", rdata0_a, (pa == 0) ? da : 32'h0);
        check("rdata1_a", rdata1_a, (pa == 1) ? da : 32'h0);
        check("rvalid0_b", rvalid0_b, pb == 0);
        check("rvalid1_b", rvalid1_b, pb == 1);
        check("rdata0_b", rdata0_b, (pb == 0) ? db : 32'h0);
        check("rdata1_b", rdata1_b, (pb == 1) ? db : 32'h0);
        s_gnt0_a = gnt0_a; s_gnt1_a = gnt1_a; s_rvalid0_a = rvalid0_a;
        s_rvalid1_a = rvalid1_a; s_rdata0_a = rdata0_a;
        s_rvalid0_b = rvalid0_b; s_rdata0_b = rdata0_b;
        last_g = g;
        @(posedge clk);
        if (rst_after) begin
            #1 rst = 1'b1;
            model_reset();
        end else begin
            if (g >= 0) begin
                if (we[g]) begin
                    mmem[addr[g][5:2]] = merge(mmem[addr[g][5:2]], wdata[g], be[g]);
                end else begin
                    due1_port[cyc+1] = g; due1_data[cyc+1] = mmem[addr[g][5:2]];
                    due2_port[cyc+2] = g; due2_data[cyc+2] = mmem[addr[g][5:2]];
                end
            end
            if (owner < 0) begin
                if (g >= 0) begin
                    favour = 1 - g;
                    if (lock[g] && MAXB > 1) begin
                        owner = g; run = 1;
                    end
                end
            end else if (g >= 0) begin
                run++;
                if (!lock[owner]) begin
                    owner = -1;
                end else if (run == MAXB) begin
                    favour = 1 - owner; owner = -1;
                end
            end else if (!lock[owner]) begin
                owner = -1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_g = -1;
        model_reset();
        for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
        for (int p = 0; p < 2; p++) set_port(p, 1, 0, 0, 32'h20 + 32'(p) * 4, 0, 4'hF);

        // Reset with both ports requesting
        rst = 1'b1; init_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_reset();
            @(negedge clk);
            init_mem = 1'b0;
        end
        rst = 1'b0;
        step(0);
        check("first_gnt0", s_gnt0_a, 1);
        step(0);
        check("second_gnt1", s_gnt1_a, 1);

        // Single read from port 0
        set_port(1, 0, 0, 0, 0, 0, 4'hF);
        set_port(0, 1, 0, 0, 32'h10, 0, 4'hF);
        step(0);
        check("rd_gnt0", s_gnt0_a, 1);
        req[0] = 0;
        step(0);
        check("rd_lat1_valid", s_rvalid0_a, 1);
        check("rd_lat1_data", s_rdata0_a, 32'hDEADBEEF);
        check("rd_lat1_other", s_rvalid1_a, 0);
        step(0);
        check("rd_lat2_valid", s_rvalid0_b, 1);
        check("rd_lat2_data", s_rdata0_b, 32'hDEADBEEF);
        step(0);

        // Round-robin between two unlocked readers
        set_port(0, 1, 0, 0, 32'h14, 0, 4'hF);
        set_port(1, 1, 0, 0, 32'h18, 0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step(0);
            check("rr_gnt1", s_gnt1_a, (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Locked write burst from port 1, port 0 reads address 0 behind it
        set_port(0, 1, 0, 0, 32'h0, 0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_port(1, 1, i < 3, 1, 32'(i) * 4, 32'h1000 + 32'(i), 4'hF);
            else set_port(1, 0, 0, 0, 0, 0, 0);
            step(0);
            check("burst_gnt1", s_gnt1_a, i < 4);
        end
        req[0] = 0;
        for (int i = 0; i < 3; i++) step(0);

        // Starvation cap with port 1 locked throughout
        set_port(0, 1, 0, 0, 32'h24, 0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            set_port(1, 1, 1, i % 3 == 0, 32'(i % 16) * 4, $urandom, 4'(i));
            step(0);
            check("starve_gnt1", s_gnt1_a, (i == 8 || i == 17) ? 1'b0 : 1'b1);
        end
        set_port(0, 0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0);

        // Reset with a read in flight
        set_port(0, 1, 0, 0, 32'h10, 0, 4'hF);
        step(1);
        check("rstmid_gnt0", s_gnt0_a, 1);
        req[0] = 0;
        for (int i = 0; i < 2; i++) begin
            #1 check_reset();
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0);
        set_port(0, 1, 0, 0, 32'h28, 0, 4'hF);
        set_port(1, 1, 0, 0, 32'h2C, 0, 4'hF);
        step(0);
        check("rstmid_rr_gnt0", s_gnt0_a, 1);
        step(0);
        check("rstmid_rr_gnt1", s_gnt1_a, 1);

        // Randomized traffic, requests held until granted
        set_port(0, 0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0, 0);
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        pend[p] = 1;
                        set_port(p, 1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                                 32'($urandom_range(0, 15)) * 4, $urandom, 4'($urandom));
                    end else begin
                        req[p] = 0;
                        lock[p] = $urandom_range(0, 1) == 1;
                    end
                end
            end
            step(0);
            for (int p = 0; p < 2; p++) if (last_g == p) pend[p] = 0;
        end
        set_port(0, 0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
